// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 port arbiter: grant-policy encoding and the
// tag-width helpers used to size the {port, mshr_id} tag.
package l2_arb_pkg;

    typedef enum int unsigned {
        PRIO_RR    = 0,
        PRIO_FIXED = 1
    } prio_mode_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned tag_bits(input int unsigned num_ports,
                                             input int unsigned mshr_id_bits);
        return mshr_id_bits + clog2(num_ports);
    endfunction

endpackage

// File: rtl/arb_fifo.sv
// Per-port request queue: 2**DEPTH_LOG entries with a first-word-fall-through read port.
module arb_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH_LOG = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o  = (count_q == (DEPTH_LOG + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates NUM_PORTS L1 request queues onto one stallable L2 request register
// and routes tagged L2 responses back to the originating port.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_WIDTH     = 256,
    parameter int unsigned MSHR_ID_BITS   = 3,
    parameter int unsigned FIFO_DEPTH_LOG = 2,
    parameter int unsigned PRIO_MODE      = 0,
    localparam int unsigned PORT_BITS     = clog2(NUM_PORTS),
    localparam int unsigned TAG_BITS      = tag_bits(NUM_PORTS, MSHR_ID_BITS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid_i,
    input  logic [NUM_PORTS-1:0]             req_rw_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_data_i,
    input  logic [NUM_PORTS*MSHR_ID_BITS-1:0] req_id_i,
    output logic [NUM_PORTS-1:0]             req_full_o,
    output logic                             l2_valid_o,
    output logic                             l2_rw_o,
    output logic [ADDR_WIDTH-1:0]            l2_addr_o,
    output logic [LINE_WIDTH-1:0]            l2_data_o,
    output logic [TAG_BITS-1:0]              l2_id_o,
    input  logic                             l2_stall_i,
    input  logic                             l2_rsp_valid_i,
    input  logic [LINE_WIDTH-1:0]            l2_rsp_data_i,
    input  logic [TAG_BITS-1:0]              l2_rsp_id_i,
    output logic [NUM_PORTS-1:0]             rsp_valid_o,
    output logic [LINE_WIDTH-1:0]            rsp_data_o,
    output logic [MSHR_ID_BITS-1:0]          rsp_id_o,
    output logic                             err_o
);

    localparam int unsigned FW = 1 + ADDR_WIDTH + LINE_WIDTH + MSHR_ID_BITS;

    logic [FW-1:0]        fifo_dout [NUM_PORTS];
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_pop;

    logic [PORT_BITS-1:0] grant_port;
    logic                 grant_found;
    logic                 loadable;
    logic                 do_grant;
    logic [FW-1:0]        sel;

    logic                    l2_valid_q, l2_valid_d;
    logic                    l2_rw_q, l2_rw_d;
    logic [ADDR_WIDTH-1:0]   l2_addr_q, l2_addr_d;
    logic [LINE_WIDTH-1:0]   l2_data_q, l2_data_d;
    logic [TAG_BITS-1:0]     l2_id_q, l2_id_d;
    logic [PORT_BITS-1:0]    last_grant_q, last_grant_d;

    logic [NUM_PORTS-1:0]    rsp_valid_q, rsp_valid_d;
    logic [LINE_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [MSHR_ID_BITS-1:0] rsp_id_q, rsp_id_d;
    logic                    err_q, err_d;
    logic [PORT_BITS:0]      rsp_port_ext;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign fifo_pop[p] = do_grant && (grant_port == PORT_BITS'(p));

        arb_fifo #(
            .WIDTH     (FW),
            .DEPTH_LOG (FIFO_DEPTH_LOG)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (req_valid_i[p]),
            .data_i  ({req_rw_i[p],
                       req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH],
                       req_data_i[p*LINE_WIDTH +: LINE_WIDTH],
                       req_id_i[p*MSHR_ID_BITS +: MSHR_ID_BITS]}),
            .pop_i   (fifo_pop[p]),
            .data_o  (fifo_dout[p]),
            .empty_o (fifo_empty[p]),
            .full_o  (req_full_o[p])
        );
    end

    // Round-robin scans from last_grant+1 and wraps, so last_grant itself is checked last.
    always_comb begin
        grant_found = 1'b0;
        grant_port  = '0;
        if (PRIO_MODE == int'(PRIO_FIXED)) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!grant_found && !fifo_empty[PORT_BITS'(i)]) begin
                    grant_found = 1'b1;
                    grant_port  = PORT_BITS'(i);
                end
            end
        end else begin
            for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
                int unsigned cand;
                cand = (int'(last_grant_q) + i) % NUM_PORTS;
                if (!grant_found && !fifo_empty[PORT_BITS'(cand)]) begin
                    grant_found = 1'b1;
                    grant_port  = PORT_BITS'(cand);
                end
            end
        end
    end

    assign loadable = ~l2_valid_q | ~l2_stall_i;
    assign do_grant = loadable & grant_found;
    assign sel      = fifo_dout[grant_port];

    always_comb begin
        l2_valid_d   = l2_valid_q;
        l2_rw_d      = l2_rw_q;
        l2_addr_d    = l2_addr_q;
        l2_data_d    = l2_data_q;
        l2_id_d      = l2_id_q;
        last_grant_d = last_grant_q;
        if (loadable) begin
            l2_valid_d = grant_found;
            if (grant_found) begin
                l2_rw_d      = sel[FW-1];
                l2_addr_d    = sel[FW-2 -: ADDR_WIDTH];
                l2_data_d    = sel[MSHR_ID_BITS +: LINE_WIDTH];
                l2_id_d      = {grant_port, sel[MSHR_ID_BITS-1:0]};
                last_grant_d = grant_port;
            end
        end
    end

    assign rsp_port_ext = {1'b0, l2_rsp_id_i[TAG_BITS-1 -: PORT_BITS]};

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        err_d       = err_q;
        if (l2_rsp_valid_i) begin
            rsp_data_d = l2_rsp_data_i;
            rsp_id_d   = l2_rsp_id_i[MSHR_ID_BITS-1:0];
            if (rsp_port_ext < (PORT_BITS + 1)'(NUM_PORTS)) begin
                rsp_valid_d = NUM_PORTS'(1) << rsp_port_ext;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l2_valid_q   <= 1'b0;
            l2_rw_q      <= 1'b0;
            l2_addr_q    <= '0;
            l2_data_q    <= '0;
            l2_id_q      <= '0;
            last_grant_q <= PORT_BITS'(NUM_PORTS - 1);
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            l2_valid_q   <= l2_valid_d;
            l2_rw_q      <= l2_rw_d;
            l2_addr_q    <= l2_addr_d;
            l2_data_q    <= l2_data_d;
            l2_id_q      <= l2_id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            err_q        <= err_d;
        end
    end

    assign l2_valid_o  = l2_valid_q;
    assign l2_rw_o     = l2_rw_q;
    assign l2_addr_o   = l2_addr_q;
    assign l2_data_o   = l2_data_q;
    assign l2_id_o     = l2_id_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign err_o       = err_q;

endmodule
